// File: rtl/dbus_arbiter_if.sv
// Bus bundle between the two data-bus masters, the arbiter and the shared
// slave side (RAM data port / Addr_Decoder / read-data mux).
// slave  : arbiter view (accepts master requests, drives the shared bus)
// master : environment view (masters issue requests, slaves return bus_rdata)
interface dbus_arbiter_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [AWIDTH-1:0] m0_addr;
    logic [DWIDTH-1:0] m0_wdata;
    logic [3:0]        m0_be;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DWIDTH-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [AWIDTH-1:0] m1_addr;
    logic [DWIDTH-1:0] m1_wdata;
    logic [3:0]        m1_be;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DWIDTH-1:0] m1_rdata;

    logic [AWIDTH-1:0] bus_addr;
    logic [DWIDTH-1:0] bus_wdata;
    logic [3:0]        bus_be;
    logic              bus_we;
    logic              bus_re;
    logic [DWIDTH-1:0] bus_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_be,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_be,
        output m1_gnt, m1_rvalid, m1_rdata,
        output bus_addr, bus_wdata, bus_be, bus_we, bus_re,
        input  bus_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_be,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_be,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  bus_addr, bus_wdata, bus_be, bus_we, bus_re,
        output bus_rdata
    );
endinterface

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter (M0 = CPU data port, M1 = DMA/debug).
// One owner at a time, bubble-free handoff, burst bounded by MAX_BURST while
// the other master waits. Read data returns one cycle after the read strobe.
// Optional macro ARB_RR_EN: idle ties alternate away from the last owner;
// without it idle ties always go to M0.
module dbus_arbiter #(
    parameter int AWIDTH    = 32,
    parameter int DWIDTH    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           reset,
    dbus_arbiter_if.slave  dbus
);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_owner_q, rd_owner_d;     // 0 = M0, 1 = M1
    logic [AWIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [DWIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [DWIDTH-1:0] m0_rdata_q, m0_rdata_d;
    logic [DWIDTH-1:0] m1_rdata_q, m1_rdata_d;
`ifdef ARB_RR_EN
    logic              last_owner_q, last_owner_d; // 0 = M0, 1 = M1
`endif

    // Current owner's request fields; in IDLE nothing is issued, so M0's
    // fields are selected harmlessly.
    logic              own1;
    logic              sel_req, sel_we, other_req;
    logic [AWIDTH-1:0] sel_addr;
    logic [DWIDTH-1:0] sel_wdata;
    logic [3:0]        sel_be;
    logic              beat;

    assign own1      = (state_q == OWN1);
    assign sel_req   = own1 ? dbus.m1_req   : dbus.m0_req;
    assign sel_we    = own1 ? dbus.m1_we    : dbus.m0_we;
    assign sel_addr  = own1 ? dbus.m1_addr  : dbus.m0_addr;
    assign sel_wdata = own1 ? dbus.m1_wdata : dbus.m0_wdata;
    assign sel_be    = own1 ? dbus.m1_be    : dbus.m0_be;
    assign other_req = own1 ? dbus.m0_req   : dbus.m1_req;
    assign beat      = (state_q != IDLE) && sel_req;

    // Next-state, burst counter and ownership-history logic
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
`ifdef ARB_RR_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            IDLE: begin
                beat_cnt_d = '0;
                if (dbus.m0_req && dbus.m1_req) begin
`ifdef ARB_RR_EN
                    state_d = last_owner_q ? OWN0 : OWN1;
`else
                    state_d = OWN0;
`endif
                end else if (dbus.m0_req) begin
                    state_d = OWN0;
                end else if (dbus.m1_req) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!sel_req) begin
                    state_d    = other_req ? (own1 ? OWN0 : OWN1) : IDLE;
                    beat_cnt_d = '0;
                end else if ((beat_cnt_q == CNT_MAX) && other_req) begin
                    state_d    = own1 ? OWN0 : OWN1;
                    beat_cnt_d = '0;
                end else if (beat_cnt_q != CNT_MAX) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
`ifdef ARB_RR_EN
        if ((state_d != state_q) && (state_d != IDLE))
            last_owner_d = (state_d == OWN1);
`endif
    end

    // Bus drive, held bus fields and read-return bookkeeping
    always_comb begin
        bus_addr_d  = beat ? sel_addr  : bus_addr_q;
        bus_wdata_d = beat ? sel_wdata : bus_wdata_q;
        bus_be_d    = beat ? sel_be    : bus_be_q;
        rd_pend_d   = beat && !sel_we;
        rd_owner_d  = beat ? own1 : rd_owner_q;
        m0_rdata_d  = dbus.m0_rvalid ? dbus.bus_rdata : m0_rdata_q;
        m1_rdata_d  = dbus.m1_rvalid ? dbus.bus_rdata : m1_rdata_q;
    end

    assign dbus.m0_gnt    = beat && !own1;
    assign dbus.m1_gnt    = beat && own1;
    assign dbus.bus_re    = beat && !sel_we;
    assign dbus.bus_we    = beat && sel_we;
    assign dbus.bus_addr  = bus_addr_d;
    assign dbus.bus_wdata = bus_wdata_d;
    assign dbus.bus_be    = bus_be_d;
    assign dbus.m0_rvalid = rd_pend_q && !rd_owner_q;
    assign dbus.m1_rvalid = rd_pend_q && rd_owner_q;
    assign dbus.m0_rdata  = m0_rdata_d;
    assign dbus.m1_rdata  = m1_rdata_d;

    // State registers; synchronous reset drops any pending read
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            rd_pend_q   <= 1'b0;
            rd_owner_q  <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
`ifdef ARB_RR_EN
            last_owner_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            rd_pend_q   <= rd_pend_d;
            rd_owner_q  <= rd_owner_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
`ifdef ARB_RR_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end
endmodule
